bounce_gen: RTL and testbench

Synthesizable contact-bounce emulator: turns a clean, synchronous level into a realistic bouncy signal for exercising the push-button debouncer on hardware and in simulation. Each level change on the clean input produces a burst of pseudo-random toggles for a fixed window, then settles to the new level. It sits in front of the debouncer's noisy input, with an FSM, counters and an LFSR. Bounce patterns are deterministic from reset for repeatable tests.

---
 rtl/bounce_gen.sv | 135 +++++++++++++
 tb/tb_bounce_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// bounce_gen: contact-bounce emulator. Turns a clean synchronous level into a
// burst of pseudo-random toggles lasting a fixed window after every level
// change, then settles on the new level. Patterns repeat exactly from reset.
module bounce_gen #(
  parameter int unsigned BOUNCE_WINDOW = 1_500_000,
  parameter int unsigned MIN_SEG       = 2000,
  parameter int unsigned SEG_BITS      = 12,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clean,
  input  logic bounce_en,
  output logic noisy,
  output logic bouncing
);

  // Window counter holds BOUNCE_WINDOW-1; at least one bit even for a 1-cycle window
  localparam int unsigned WIN_W = (BOUNCE_WINDOW > 1) ? $clog2(BOUNCE_WINDOW) : 1;
  // Segment counter must hold the longest reload value MIN_SEG+2^SEG_BITS-2
  localparam int unsigned SEG_W = $clog2(MIN_SEG + (1 << SEG_BITS));
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BOUNCE_WINDOW - 1);
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    IDLE,
    BOUNCE
  } state_e;

  state_e           state_q,    state_d;
  logic             level_q,    level_d;
  logic             target_q,   target_d;
  logic             noisy_q,    noisy_d;
  logic             bouncing_q, bouncing_d;
  logic [WIN_W-1:0] winCnt_q,   winCnt_d;
  logic [SEG_W-1:0] segCnt_q,   segCnt_d;
  logic [15:0]      lfsr_q,     lfsr_d;

  logic [SEG_W-1:0] segLoad;
  logic [15:0]      lfsrNext;

  // Next segment length minus one comes from the current (pre-advance) LFSR value
  assign segLoad  = SEG_W'(MIN_SEG - 1) + SEG_W'(lfsr_q[SEG_BITS-1:0]);
  assign lfsrNext = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

  assign noisy    = noisy_q;
  assign bouncing = bouncing_q;

  // State register; reset returns to a settled low level with the seed reloaded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      level_q    <= 1'b0;
      target_q   <= 1'b0;
      noisy_q    <= 1'b0;
      bouncing_q <= 1'b0;
      winCnt_q   <= '0;
      segCnt_q   <= '0;
      lfsr_q     <= SEED;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      target_q   <= target_d;
      noisy_q    <= noisy_d;
      bouncing_q <= bouncing_d;
      winCnt_q   <= winCnt_d;
      segCnt_q   <= segCnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // Next-state logic: start/restart windows on level changes, toggle per segment
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    target_d   = target_q;
    noisy_d    = noisy_q;
    bouncing_d = bouncing_q;
    winCnt_d   = winCnt_q;
    segCnt_d   = segCnt_q;
    lfsr_d     = lfsr_q;

    case (state_q)
      IDLE: begin
        if (!bounce_en) begin
          noisy_d    = clean;
          level_d    = clean;
          bouncing_d = 1'b0;
        end else if (clean != level_q) begin
          target_d   = clean;
          noisy_d    = clean;
          winCnt_d   = WIN_LOAD;
          segCnt_d   = segLoad;
          lfsr_d     = lfsrNext;
          bouncing_d = 1'b1;
          state_d    = BOUNCE;
        end
      end

      BOUNCE: begin
        if (!bounce_en) begin
          noisy_d    = clean;
          level_d    = clean;
          bouncing_d = 1'b0;
          state_d    = IDLE;
        end else if (clean != target_q) begin
          target_d = clean;
          noisy_d  = clean;
          winCnt_d = WIN_LOAD;
          segCnt_d = segLoad;
          lfsr_d   = lfsrNext;
        end else if (winCnt_q == '0) begin
          noisy_d    = target_q;
          level_d    = target_q;
          bouncing_d = 1'b0;
          state_d    = IDLE;
        end else if (segCnt_q == '0) begin
          noisy_d  = ~noisy_q;
          segCnt_d = segLoad;
          lfsr_d   = lfsrNext;
          winCnt_d = winCnt_q - 1'b1;
        end else begin
          segCnt_d = segCnt_q - 1'b1;
          winCnt_d = winCnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: self-checking bench for bounce_gen with a small window.
// A timestamp-based reference model predicts noisy/bouncing every cycle.
module tb_bounce_gen;

  localparam int unsigned W_TB    = 64;
  localparam int unsigned MS_TB   = 2;
  localparam int unsigned SB_TB   = 3;
  localparam logic [15:0] SEED_TB = 16'hACE1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clean = 1'b0;
  logic bounce_en = 1'b0;
  logic noisy;
  logic bouncing;

  int checks = 0;
  int errors = 0;

  bounce_gen #(
    .BOUNCE_WINDOW(W_TB),
    .MIN_SEG(MS_TB),
    .SEG_BITS(SB_TB),
    .SEED(SEED_TB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clean(clean),
    .bounce_en(bounce_en),
    .noisy(noisy),
    .bouncing(bouncing)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Reference model: absolute cycle stamps for window end and next toggle
  longint     tNow = 0;
  longint     winEnd = 0;
  longint     segEnd = 0;
  logic [15:0] mLfsr = SEED_TB;
  logic       mLevel = 1'b0;
  logic       mTarget = 1'b0;
  logic       mNoisy = 1'b0;
  logic       mBouncing = 1'b0;

  function automatic logic [15:0] lfsrStep(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic longint segLen(input logic [15:0] x);
    return longint'(MS_TB) + longint'(int'(x) % (1 << SB_TB));
  endfunction

  task automatic modelReset();
    mLfsr = SEED_TB; mLevel = 1'b0; mTarget = 1'b0;
    mNoisy = 1'b0; mBouncing = 1'b0;
  endtask

  task automatic startWindow(input logic c);
    mTarget   = c;
    mNoisy    = c;
    winEnd    = tNow + longint'(W_TB);
    segEnd    = tNow + segLen(mLfsr);
    mLfsr     = lfsrStep(mLfsr);
    mBouncing = 1'b1;
  endtask

  task automatic modelEdge(input logic c, input logic en);
    tNow++;
    if (!mBouncing) begin
      if (!en) begin
        mNoisy = c; mLevel = c;
      end else if (c != mLevel) begin
        startWindow(c);
      end
    end else begin
      if (!en) begin
        mBouncing = 1'b0; mNoisy = c; mLevel = c;
      end else if (c != mTarget) begin
        startWindow(c);
      end else if (tNow == winEnd) begin
        mNoisy = mTarget; mLevel = mTarget; mBouncing = 1'b0;
      end else if (tNow == segEnd) begin
        mNoisy = !mNoisy;
        segEnd = tNow + segLen(mLfsr);
        mLfsr  = lfsrStep(mLfsr);
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model
  task automatic applyStimulus(input logic c, input logic en);
    clean = c;
    bounce_en = en;
    @(posedge clk);
    modelEdge(c, en);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0b expected %0b", name, $time, actual, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("model_noisy", noisy, mNoisy);
    checkOutput("model_bouncing", bouncing, mBouncing);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    clean = 1'b0;
    bounce_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    modelReset();
  endtask

  typedef struct {
    logic clean;
    logic en;
    logic expNoisy;
    logic expBouncing;
  } vec_t;

  vec_t vecs[10];
  logic traceA[80];
  logic traceB[80];

  initial begin
    int runLen;
    logic c;
    logic en;

    // Table: pass-through, idle with no change, then a bounce entry
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1};

    // Reset idle: clean low, nothing should happen for 100 cycles
    doReset();
    checkOutput("reset_noisy", noisy, 1'b0);
    checkOutput("reset_bouncing", bouncing, 1'b0);
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("idle_noisy", noisy, 1'b0);
      checkOutput("idle_bouncing", bouncing, 1'b0);
    end

    // Single press: immediate noisy edge, 64-cycle window, bounded runs, settle high
    doReset();
    runLen = 0;
    for (int k = 0; k < 80; k++) begin
      applyStimulus(1'b1, 1'b1);
      traceA[k] = noisy;
      checkModel();
      checkOutput("press_bouncing", bouncing, (k < 64) ? 1'b1 : 1'b0);
      if (k == 0) begin
        checkOutput("press_first_edge", noisy, 1'b1);
        runLen = 1;
      end else if (k < 64) begin
        if (traceA[k] != traceA[k-1]) begin
          checks++;
          if (runLen < int'(MS_TB) || runLen > int'(MS_TB) + (1 << SB_TB) - 1) begin
            errors++;
            $display("[TB] FAIL run_length at %0t: got %0d expected %0d..%0d",
                     $time, runLen, MS_TB, MS_TB + (1 << SB_TB) - 1);
          end
          runLen = 1;
        end else begin
          runLen++;
        end
      end else begin
        checkOutput("press_settled", noisy, 1'b1);
      end
    end

    // Determinism: press, async reset mid-bounce, repeat the press
    doReset();
    for (int k = 0; k < 30; k++) applyStimulus(1'b1, 1'b1);
    checkOutput("pre_reset_bouncing", bouncing, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_noisy", noisy, 1'b0);
    checkOutput("async_reset_bouncing", bouncing, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    modelReset();
    for (int k = 0; k < 80; k++) begin
      applyStimulus(1'b1, 1'b1);
      traceB[k] = noisy;
      checkModel();
    end
    for (int k = 0; k < 80; k++) checkOutput("determinism", traceB[k], traceA[k]);

    // Release mid-bounce: window restarts at the release and settles low
    doReset();
    for (int k = 0; k < 91; k++) begin
      applyStimulus((k < 20) ? 1'b1 : 1'b0, 1'b1);
      checkModel();
      checkOutput("release_bouncing", bouncing, (k <= 83) ? 1'b1 : 1'b0);
      if (k >= 84) checkOutput("release_settled", noisy, 1'b0);
    end

    // Table-driven vectors from a fresh reset
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].clean, vecs[i].en);
      checkOutput("vec_noisy", noisy, vecs[i].expNoisy);
      checkOutput("vec_bouncing", bouncing, vecs[i].expBouncing);
    end

    // Random pass-through: noisy follows clean one cycle later
    for (int k = 0; k < 60; k++) begin
      c = 1'($urandom);
      applyStimulus(c, 1'b0);
      checkOutput("pass_noisy", noisy, c);
      checkOutput("pass_bouncing", bouncing, 1'b0);
    end

    // Random mixed stimulus against the model
    c = clean;
    en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) c = !c;
      if ($urandom_range(0, 299) == 0) en = !en;
      applyStimulus(c, en);
      checkModel();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
